// File: rtl/multiplier_input_conditioner.sv
// Input conditioning in front of the shift-add multiplier: synchronizes and debounces
// the two KEY buttons into single-cycle pulses and the slide switches into a stable operand.
module multiplier_input_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run_key_n,
  input  logic       Clear_key_n,
  input  logic [7:0] SW_raw,
  output logic       Run,
  output logic       Reset_Load_Clear,
  output logic [7:0] SW,
  output logic       SW_changed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;

  logic [1:0] key_raw;   // bit 0 = Run, bit 1 = Clear
  logic [1:0] fire;
  logic [1:0] held;
  logic       run_nxt;
  logic       clr_nxt;

  assign key_raw = {Clear_key_n, Run_key_n};

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync;
    logic                   sample;
    btn_state_t             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   fire_q, fire_nxt;

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        sync   <= '1;
        state  <= IDLE;
        cnt    <= '0;
        fire_q <= 1'b0;
      end else begin
        sync   <= {sync[SYNC_STAGES-2:0], key_raw[b]};
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        fire_q <= fire_nxt;
      end
    end

    assign sample = ~sync[SYNC_STAGES-1];

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      fire_nxt  = 1'b0;
      unique case (state)
        IDLE: begin
          if (sample) begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!sample) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == DEB_C) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
            fire_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sample) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (sample) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt == DEB_C) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign fire[b] = fire_q;
    assign held[b] = (state == PRESSED);
  end

  // Fire is registered inside each FSM, then arbitrated here: Clear wins, and a Run
  // fire while Clear is held is discarded rather than queued.
  assign clr_nxt = fire[1];
  assign run_nxt = fire[0] & ~held[1];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Run              <= 1'b0;
      Reset_Load_Clear <= 1'b0;
    end else begin
      Run              <= run_nxt;
      Reset_Load_Clear <= clr_nxt;
    end
  end

  logic [7:0]       sw_sync [SYNC_STAGES];
  logic [7:0]       sw_sample;
  logic [7:0]       cand, cand_nxt;
  logic [CNT_W-1:0] sw_cnt, sw_cnt_nxt, sw_cnt_inc;
  logic [7:0]       sw_nxt;
  logic             sw_chg_nxt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
      cand       <= '0;
      sw_cnt     <= '0;
      SW         <= '0;
      SW_changed <= 1'b0;
    end else begin
      sw_sync[0] <= SW_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
      cand       <= cand_nxt;
      sw_cnt     <= sw_cnt_nxt;
      SW         <= sw_nxt;
      SW_changed <= sw_chg_nxt;
    end
  end

  assign sw_sample = sw_sync[SYNC_STAGES-1];

  // A qualified update colliding with an outgoing pulse holds the counter saturated,
  // so it lands on the following cycle while the sample still matches.
  always_comb begin
    cand_nxt   = cand;
    sw_cnt_nxt = sw_cnt;
    sw_nxt     = SW;
    sw_chg_nxt = 1'b0;
    sw_cnt_inc = (sw_cnt == DEB_C) ? DEB_C : sw_cnt + 1'b1;
    if (sw_sample != cand) begin
      cand_nxt   = sw_sample;
      sw_cnt_nxt = '0;
    end else if (cand != SW) begin
      if (sw_cnt_inc == DEB_C && !(run_nxt || clr_nxt)) begin
        sw_nxt     = cand;
        sw_chg_nxt = 1'b1;
        sw_cnt_nxt = '0;
      end else begin
        sw_cnt_nxt = sw_cnt_inc;
      end
    end else begin
      sw_cnt_nxt = '0;
    end
  end

endmodule

// File: tb/tb_multiplier_input_conditioner.sv
// Bench for multiplier_input_conditioner: run-length debounce model checked every cycle
// plus directed scenarios with hand-computed pulse and operand timing.
module tb_multiplier_input_conditioner;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       Run_key_n = 1'b1;
  logic       Clear_key_n = 1'b1;
  logic [7:0] SW_raw = 8'h00;
  logic       Run, Reset_Load_Clear, SW_changed;
  logic [7:0] SW;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 Clk = ~Clk;

  multiplier_input_conditioner #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .Run_key_n(Run_key_n),
    .Clear_key_n(Clear_key_n),
    .SW_raw(SW_raw),
    .Run(Run),
    .Reset_Load_Clear(Reset_Load_Clear),
    .SW(SW),
    .SW_changed(SW_changed)
  );

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: inputs reach the logic SYNC edges late; a level is accepted once DEB+1
  // consecutive samples agree on it.
  logic [9:0] dly[$];
  bit         m_lvl[2];
  int         m_cnt[2];
  bit         m_fire_q[2];
  bit         m_clr_held;
  logic [7:0] m_last;
  int         m_len;
  logic       m_run, m_rlc, m_chg;
  logic [7:0] m_sw;

  task automatic model_reset();
    dly.delete();
    for (int k = 0; k < SYNC; k++) dly.push_back({2'b11, 8'h00});
    for (int b = 0; b < 2; b++) begin
      m_lvl[b] = 1'b0; m_cnt[b] = 0; m_fire_q[b] = 1'b0;
    end
    m_clr_held = 1'b0;
    m_last = 8'h00; m_len = 1;
    m_run = 1'b0; m_rlc = 1'b0; m_chg = 1'b0; m_sw = 8'h00;
  endtask

  always @(posedge Clk or negedge Reset_n) begin
    logic [9:0] s;
    bit p[2];
    if (!Reset_n) begin
      model_reset();
    end else begin
      dly.push_back({Clear_key_n, Run_key_n, SW_raw});
      s = dly.pop_front();
      p[0] = !s[8];
      p[1] = !s[9];
      m_rlc = m_fire_q[1];
      m_run = m_fire_q[0] && !m_clr_held;
      for (int b = 0; b < 2; b++) begin
        m_fire_q[b] = 1'b0;
        if (p[b] != m_lvl[b]) m_cnt[b]++;
        else m_cnt[b] = 0;
        if (m_cnt[b] == DEB + 1) begin
          m_lvl[b] = p[b];
          m_cnt[b] = 0;
          m_fire_q[b] = p[b];
        end
      end
      m_clr_held = m_lvl[1] && (m_cnt[1] == 0);
      if (s[7:0] == m_last) begin
        if (m_len < 1000) m_len++;
      end else begin
        m_last = s[7:0];
        m_len = 1;
      end
      m_chg = 1'b0;
      if (s[7:0] != m_sw && m_len >= DEB + 1 && !(m_run || m_rlc)) begin
        m_sw = s[7:0];
        m_chg = 1'b1;
      end
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      check_bit("model_run", Run, m_run);
      check_bit("model_rlc", Reset_Load_Clear, m_rlc);
      check_byte("model_sw", SW, m_sw);
      check_bit("model_sw_changed", SW_changed, m_chg);
    end
  end

  task automatic tick(input int i, input int run_e, input int rlc_e,
                      input logic [7:0] sw_e, input logic chg_e, input string tag);
    @(posedge Clk);
    #1;
    check_bit({tag, "_run"}, Run, (i == run_e));
    check_bit({tag, "_rlc"}, Reset_Load_Clear, (i == rlc_e));
    check_byte({tag, "_sw"}, SW, sw_e);
    check_bit({tag, "_sw_changed"}, SW_changed, chg_e);
  endtask

  function automatic logic bounce_pat(input int n);
    if (n == 1 || n == 3) return 1'b1;
    if (n <= 13) return 1'b0;
    if (n == 14 || n == 15) return 1'b1;
    if (n == 16 || n == 17) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    model_reset();
    #1 Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_bit("reset_run", Run, 1'b0);
    check_bit("reset_rlc", Reset_Load_Clear, 1'b0);
    check_byte("reset_sw", SW, 8'h00);
    check_bit("reset_sw_changed", SW_changed, 1'b0);
    Reset_n = 1'b1;
    cmp_en = 1'b1;
    for (int i = 0; i < 10; i++) tick(i, -1, -1, 8'h00, 1'b0, "idle");

    // Clean press: Run 7 edges after the first sampling edge
    Run_key_n = 1'b0;
    for (int i = 0; i < 20; i++) tick(i, 7, -1, 8'h00, 1'b0, "clean");
    Run_key_n = 1'b1;
    for (int i = 0; i < 20; i++) tick(i, -1, -1, 8'h00, 1'b0, "clean_rel");

    // Bouncy press and bouncy release: one pulse timed from the last fall at edge 4
    Run_key_n = bounce_pat(0);
    for (int i = 0; i < 36; i++) begin
      tick(i, 11, -1, 8'h00, 1'b0, "bounce");
      Run_key_n = bounce_pat(i + 1);
    end
    Run_key_n = 1'b1;

    // Simultaneous press: Clear only; releasing Clear first never revives Run
    Run_key_n = 1'b0;
    Clear_key_n = 1'b0;
    for (int i = 0; i < 20; i++) tick(i, -1, 7, 8'h00, 1'b0, "simul");
    Clear_key_n = 1'b1;
    for (int i = 0; i < 20; i++) tick(i, -1, -1, 8'h00, 1'b0, "clr_first");
    Run_key_n = 1'b1;
    for (int i = 0; i < 20; i++) tick(i, -1, -1, 8'h00, 1'b0, "simul_rel");

    // Switch change with a 2-cycle single-bit glitch
    SW_raw = 8'hA5;
    for (int i = 0; i < 20; i++) begin
      tick(i, -1, -1, (i >= 10) ? 8'hA5 : 8'h00, (i == 10), "sw_glitch");
      SW_raw = (i + 1 == 2 || i + 1 == 3) ? 8'hA4 : 8'hA5;
    end

    // Short excursion must not be accepted
    SW_raw = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      tick(i, -1, -1, 8'hA5, 1'b0, "sw_excursion");
      SW_raw = (i + 1 <= 2) ? 8'hFF : 8'hA5;
    end

    // Switch update lands on the Run edge: deferred by one cycle
    Run_key_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(i, 7, -1, (i >= 8) ? 8'h3C : 8'hA5, (i == 8), "collide");
      SW_raw = 8'h3C;
    end
    Run_key_n = 1'b1;
    for (int i = 0; i < 20; i++) tick(i, -1, -1, 8'h3C, 1'b0, "collide_rel");

    // Asynchronous reset while the press is being debounced
    Run_key_n = 1'b0;
    for (int i = 0; i < 3; i++) tick(i, -1, -1, 8'h3C, 1'b0, "pre_reset");
    #3 Reset_n = 1'b0;
    #1;
    check_bit("async_run", Run, 1'b0);
    check_bit("async_rlc", Reset_Load_Clear, 1'b0);
    check_byte("async_sw", SW, 8'h00);
    check_bit("async_sw_changed", SW_changed, 1'b0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    for (int i = 0; i < 20; i++) tick(i, 7, -1, (i >= 6) ? 8'h3C : 8'h00, (i == 6), "post_reset");
    Run_key_n = 1'b1;
    for (int i = 0; i < 20; i++) tick(i, -1, -1, 8'h3C, 1'b0, "final_idle");

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplier_input_conditioner.md
Name: multiplier_input_conditioner

Overview:
- Front-end stage directly upstream of the 8-bit shift-add multiplier on the DE10 board.
- Takes the raw, asynchronous, bouncy KEY push-buttons and SW slide switches, and synchronizes and debounces them.
- Delivers clean single-cycle Run and Reset_Load_Clear pulses plus a stable 8-bit operand bus to the multiplier.
- Ensures one physical press produces exactly one multiply or load/clear operation.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each input synchronizer chain (minimum 2).
- DEBOUNCE_CYCLES, 50000, consecutive stable sync samples required before accepting a level change (1 ms at 50 MHz); minimum 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each debounce counter (derived; not overridden).

Ports:
- Clk, input, 1, system clock (50 MHz).
- Reset_n, input, 1, asynchronous active-low reset.
- Run_key_n, input, 1, raw Run push-button, active-low (pressed = 0).
- Clear_key_n, input, 1, raw Reset_Load_Clear push-button, active-low.
- SW_raw, input, 8, raw slide switches.
- Run, output, 1, one-cycle Run pulse to the multiplier.
- Reset_Load_Clear, output, 1, one-cycle load/clear pulse to the multiplier.
- SW, output, 8, debounced switch value to the multiplier.
- SW_changed, output, 1, one-cycle pulse when SW takes a new value.

Behaviour:
- Reset state (Reset_n = 0, asynchronous): all synchronizer flops = released/0; all counters = 0; button FSMs in IDLE; Run = 0, Reset_Load_Clear = 0, SW = 8'h00, SW_changed = 0.
- Synchronizers:
  - Each button and each SW bit passes through its own SYNC_STAGES-flop chain.
  - Button chains reset to 1 (released); SW chains reset to 0.
  - Button samples are inverted after sync, so pressed = 1 internally.
- Button FSM, one per button, states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - IDLE: sample pressed -> PRESS_WAIT, counter = 1.
  - PRESS_WAIT:
    - sample released -> IDLE, counter = 0;
    - sample pressed and counter == DEBOUNCE_CYCLES -> PRESSED, fire pulse;
    - else counter++.
  - PRESSED: sample released -> RELEASE_WAIT, counter = 1; otherwise hold with no pulse, however long the press.
  - RELEASE_WAIT:
    - sample pressed -> PRESSED, counter = 0, no new pulse;
    - released and counter == DEBOUNCE_CYCLES -> IDLE;
    - else counter++.
- Pulse output is registered and high for exactly 1 cycle.
- Latency from the first Clk edge sampling a clean press to the pulse high = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- Bounce handling: any glitch shorter than DEBOUNCE_CYCLES in PRESS_WAIT restarts from IDLE and produces no pulse. Bounce during release never produces a pulse.
- Priority:
  - If both FSMs would fire in the same cycle, only Reset_Load_Clear is asserted; the Run pulse is dropped, not deferred.
  - Run firing while the Clear FSM is in PRESSED is also dropped.
- SW debounce:
  - One shared counter for the whole 8-bit bus. Each cycle the synchronized bus is compared with a candidate register.
  - Mismatch -> candidate = sample, counter = 0.
  - Match and candidate != SW -> counter++; at counter == DEBOUNCE_CYCLES, SW <= candidate and SW_changed pulses 1 cycle.
  - Match and candidate == SW -> counter = 0.
- SW stability across pulses:
  - SW does not change in the same cycle Run or Reset_Load_Clear is high.
  - If an SW update coincides with a pulse, the update is deferred 1 cycle.
  - This guarantees the multiplier loads a stable operand.
- Reset mid-operation: asserting Reset_n at any point immediately returns every state and output to reset values. No pulse is emitted on deassertion, even if a button is held. A held button must still be debounced from IDLE, firing once after the full latency.
- Counter saturation: counters never exceed DEBOUNCE_CYCLES; no wrap-around.

Test Plan (DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2 in simulation):
- Clean press: Run_key_n 1->0 held 20 cycles -> Run = 1 for exactly one cycle, 7 cycles after the first sampling edge; Reset_Load_Clear stays 0.
- Bouncy press: Run_key_n toggles 0,1,0,1 with 1-cycle periods, then low 10 cycles -> exactly one Run pulse, timed from the last falling transition. Releasing with 2-cycle bounces -> no additional pulse.
- Simultaneous: both keys go low on the same edge and are held -> Reset_Load_Clear pulses once, Run never pulses. Releasing Clear first while Run is held -> still no Run pulse.
- SW debounce: SW_raw 8'h00 -> 8'hA5, with one bit glitching for 2 cycles midway -> SW becomes 8'hA5 exactly once, with a single SW_changed pulse, 4 stable cycles after the glitch ends. A 3-cycle excursion to 8'hFF -> SW unchanged.
- SW vs pulse collision: arrange the SW update and the Run pulse in the same cycle -> Run asserts with the old SW; SW and SW_changed update one cycle later.
- Async reset mid-press: Reset_n low for 1 cycle while in PRESS_WAIT with the key held -> outputs 0 immediately (between clock edges); after release of reset, one Run pulse 7 cycles later; SW = 8'h00 until re-debounced.
